// File: rtl/dmem_responder.sv
// Data-memory responder: serialises one load/store at a time over valid/ready channels with a fixed access latency.
// Define DMEM_PIPE_EN to let a new request be accepted on the same edge that the previous response retires.
module dmem_responder #(
  parameter int DATA_BITS      = 32,
  parameter int WORD_ADDR_BITS = 14,
  parameter int LATENCY        = 2,
  parameter int TAG_BITS       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [DATA_BITS-1:0]   req_wdata,
  input  logic [DATA_BITS/8-1:0] req_be,
  input  logic [TAG_BITS-1:0]    req_tag,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_BITS-1:0]   resp_rdata,
  output logic [TAG_BITS-1:0]    resp_tag,
  output logic                   resp_err
);

  localparam int BE_BITS = DATA_BITS / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_BITS-1:0]  resp_rdata_q, resp_rdata_d;
  logic [TAG_BITS-1:0]   resp_tag_q, resp_tag_d;
  logic                  resp_err_q, resp_err_d;

  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_BITS-1:0]  wdata_q, wdata_d;
  logic [BE_BITS-1:0]    be_q, be_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;

  logic [DATA_BITS-1:0]      mem [2**WORD_ADDR_BITS];
  logic [WORD_ADDR_BITS-1:0] word_idx;
  logic                      access;
  logic                      acc_err;
  logic                      mem_we;
  logic [DATA_BITS-1:0]      mem_rd;
  logic                      capture;

  assign word_idx = addr_q[WORD_ADDR_BITS+1:2];
  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
  // Any set bit above the word index means the address is outside the array.
  assign acc_err  = (addr_q[1:0] != 2'b00) || ((addr_q >> (WORD_ADDR_BITS + 2)) != 32'd0);
  assign mem_we   = access && we_q && !acc_err;
  assign mem_rd   = mem[word_idx];

`ifdef DMEM_PIPE_EN
  assign req_ready = req_ready_q || ((state_q == RESP) && resp_ready);
`else
  assign req_ready = req_ready_q;
`endif

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_tag   = resp_tag_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_tag_d   = resp_tag_q;
    resp_err_d   = resp_err_q;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) capture = 1'b1;
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = RESP;
          resp_err_d   = acc_err;
          resp_rdata_d = (!we_q && !acc_err) ? mem_rd : '0;
          resp_tag_d   = tag_q;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
`ifdef DMEM_PIPE_EN
          if (req_valid) capture = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      state_d = BUSY;
      cnt_d   = 4'(LATENCY - 1);
    end
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    tag_d   = tag_q;
    if (capture) begin
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
      tag_d   = req_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_tag_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_tag_q   <= resp_tag_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Captured request fields are only consumed while BUSY, so they need no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    tag_q   <= tag_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_BITS; i++) begin
        if (be_q[i]) mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: handshakes, byte enables, error flagging, backpressure, reset, throughput.
module tb_dmem_responder;

  localparam int LAT = 2;
`ifdef DMEM_PIPE_EN
  localparam int EXP_GAP = LAT + 1;
`else
  localparam int EXP_GAP = LAT + 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [3:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [3:0]  resp_tag;
  logic        resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(
    .DATA_BITS(32), .WORD_ADDR_BITS(14), .LATENCY(LAT), .TAG_BITS(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_tag(resp_tag), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Presents one request, waits for acceptance, then counts cycles until resp_valid.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [3:0] tag, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_tag = tag;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (resp_valid !== 1'b1 && lat < 50);
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({req_ready, resp_valid, resp_err} !== 3'b000 || resp_rdata !== 32'h0 || resp_tag !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h tag=%h, expected all zero",
               req_ready, resp_valid, resp_err, resp_rdata, resp_tag);
    end
    @(negedge clk) reset = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_before_edge: got %b expected 0", req_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_rise: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_store_load();
    int lat;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd3, lat);
    n_tests++;
    if (lat != LAT) begin n_fail++; $display("FAIL store_latency: got %0d expected %0d", lat, LAT); end
    n_tests++;
    if (resp_tag !== 4'd3 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL store_resp: got tag=%h err=%b rdata=%h expected tag=3 err=0 rdata=0", resp_tag, resp_err, resp_rdata);
    end
    take_resp();
    n_tests++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL store_retire: got vld=%b expected 0", resp_valid); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, 4'd5, lat);
    n_tests++;
    if (lat != LAT) begin n_fail++; $display("FAIL load_latency: got %0d expected %0d", lat, LAT); end
    n_tests++;
    if (resp_rdata !== 32'hDEADBEEF || resp_tag !== 4'd5 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_data: got rdata=%h tag=%h err=%b expected DEADBEEF 5 0", resp_rdata, resp_tag, resp_err);
    end
    take_resp();
  endtask

  task automatic test_byte_enable();
    int lat;
    issue(1'b1, 32'h10, 32'h000000AA, 4'h1, 4'd1, lat);
    take_resp();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 4'd2, lat);
    n_tests++;
    if (resp_rdata !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL be_low_byte: got %h expected DEADBEAA", resp_rdata);
    end
    take_resp();
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 4'd6, lat);
    n_tests++;
    if (lat != LAT || resp_tag !== 4'd6 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL be_zero_resp: got lat=%0d tag=%h err=%b expected %0d 6 0", lat, resp_tag, resp_err, LAT);
    end
    take_resp();
    issue(1'b1, 32'h10, 32'h55667788, 4'h8, 4'd7, lat);
    take_resp();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 4'd8, lat);
    n_tests++;
    if (resp_rdata !== 32'h55ADBEAA) begin
      n_fail++; $display("FAIL be_high_byte: got %h expected 55ADBEAA", resp_rdata);
    end
    take_resp();
  endtask

  task automatic test_errors();
    int lat;
    issue(1'b0, 32'h12, 32'h0, 4'h0, 4'd4, lat);
    n_tests++;
    if (resp_err !== 1'b1 || resp_rdata !== 32'h0 || resp_tag !== 4'd4) begin
      n_fail++; $display("FAIL misaligned_load: got err=%b rdata=%h tag=%h expected 1 0 4", resp_err, resp_rdata, resp_tag);
    end
    take_resp();
    issue(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 4'd4, lat);
    n_tests++;
    if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL misaligned_store: got err=%b rdata=%h expected 1 0", resp_err, resp_rdata);
    end
    take_resp();
    issue(1'b1, 32'h00010010, 32'hFFFFFFFF, 4'hF, 4'd4, lat);
    n_tests++;
    if (resp_err !== 1'b1) begin n_fail++; $display("FAIL range_store: got err=%b expected 1", resp_err); end
    take_resp();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 4'd4, lat);
    n_tests++;
    if (resp_rdata !== 32'h55ADBEAA || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL err_no_write: got rdata=%h err=%b expected 55ADBEAA 0", resp_rdata, resp_err);
    end
    take_resp();
    issue(1'b0, 32'h00010000, 32'h0, 4'h0, 4'd9, lat);
    n_tests++;
    if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL range_load: got err=%b rdata=%h expected 1 0", resp_err, resp_rdata);
    end
    take_resp();
    issue(1'b1, 32'h0000FFFC, 32'hCAFEF00D, 4'hF, 4'd10, lat);
    take_resp();
    issue(1'b0, 32'h0000FFFC, 32'h0, 4'h0, 4'd11, lat);
    n_tests++;
    if (resp_err !== 1'b0 || resp_rdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL top_word: got err=%b rdata=%h expected 0 CAFEF00D", resp_err, resp_rdata);
    end
    take_resp();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 4'd9, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h55ADBEAA || resp_tag !== 4'd9 ||
          resp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got vld=%b rdata=%h tag=%h err=%b rdy=%b expected 1 55ADBEAA 9 0 0",
                 c, resp_valid, resp_rdata, resp_tag, resp_err, req_ready);
      end
    end
    take_resp();
    n_tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got vld=%b rdy=%b expected 0 1", resp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_single: got vld=%b expected 0", resp_valid); end
  endtask

  task automatic test_reset_busy();
    int lat;
    issue(1'b1, 32'h20, 32'h0BADF00D, 4'hF, 4'd2, lat);
    take_resp();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF; req_tag = 4'd12;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL busy_reset_async: got vld=%b rdy=%b expected 0 0", resp_valid, req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL busy_reset_hold %0d: got vld=%b expected 0", c, resp_valid); end
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL busy_reset_release: got rdy=%b vld=%b expected 1 0", req_ready, resp_valid);
    end
    issue(1'b0, 32'h20, 32'h0, 4'h0, 4'd13, lat);
    n_tests++;
    if (resp_rdata !== 32'h0BADF00D || resp_tag !== 4'd13) begin
      n_fail++; $display("FAIL busy_reset_no_store: got rdata=%h tag=%h expected 0BADF00D d", resp_rdata, resp_tag);
    end
    take_resp();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp_d [4];
    int  cyc, k, r, last;
    logic acc, rv;
    logic [3:0] rtag;
    logic [31:0] rdat;
    addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h10; addrs[3] = 32'h20;
    exp_d[0] = 32'h55ADBEAA; exp_d[1] = 32'h0BADF00D; exp_d[2] = 32'h55ADBEAA; exp_d[3] = 32'h0BADF00D;
    cyc = 0; k = 0; r = 0; last = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addrs[0]; req_wdata = 32'h0; req_be = 4'h0; req_tag = 4'd1;
    resp_ready = 1'b1;
    while (r < 4 && cyc < 100) begin
      acc = req_valid && req_ready; rv = resp_valid; rtag = resp_tag; rdat = resp_rdata;
      @(posedge clk);
      cyc++;
      if (rv) begin
        n_tests++;
        if (rtag !== 4'(r + 1) || rdat !== exp_d[r]) begin
          n_fail++; $display("FAIL b2b_resp %0d: got tag=%h rdata=%h expected tag=%h rdata=%h", r, rtag, rdat, 4'(r + 1), exp_d[r]);
        end
        if (r > 0) begin
          n_tests++;
          if (cyc - last != EXP_GAP) begin
            n_fail++; $display("FAIL b2b_gap %0d: got %0d cycles expected %0d", r, cyc - last, EXP_GAP);
          end
        end
        last = cyc;
        r++;
      end
      if (acc) begin
        k++;
        #1;
        if (k < 4) begin req_addr = addrs[k]; req_tag = 4'(k + 1); end
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_tests++;
    if (r != 4) begin n_fail++; $display("FAIL b2b_count: got %0d responses expected 4", r); end
    req_valid = 1'b0;
    resp_ready = 1'b0;
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0; req_tag = 4'h0;
    resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
